// File: rtl/turing_core_param.sv
// turing_core_param: single-tape Turing machine with programmable transition table
module turing_core_param #(
  parameter int TAPE_LEN  = 16,
  parameter int SYM_W     = 2,
  parameter int STATE_W   = 3,
  parameter int WRAP      = 1,
  parameter int MAX_STEPS = 1023,
  localparam int AW = $clog2(TAPE_LEN),
  localparam int IW = STATE_W + SYM_W,
  localparam int EW = IW + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               prog_we,
  input  logic [IW-1:0]      prog_addr,
  input  logic [EW-1:0]      prog_data,
  input  logic               tape_we,
  input  logic [AW-1:0]      tape_addr,
  input  logic [SYM_W-1:0]   tape_wdata,
  output logic [SYM_W-1:0]   tape_rdata,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic               timeout,
  output logic [AW-1:0]      head,
  output logic [STATE_W-1:0] state,
  output logic [15:0]        steps
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} fsm_e;
  fsm_e               fsm_q, fsm_d;
  logic [SYM_W-1:0]   tape_q [TAPE_LEN];
  logic [EW-1:0]      tbl_q [2**IW];
  logic [EW-1:0]      ent_q, ent_d;
  logic [AW-1:0]      head_q, head_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [15:0]        steps_q, steps_d;
  logic               halted_q, halted_d, fault_q, fault_d, timeout_q, timeout_d;
  logic               tape_wr, off_end, limit;
  logic [1:0]         mv;
  assign mv = ent_q[1:0];
  assign busy = (fsm_q == FETCH) || (fsm_q == EXEC);
  assign off_end = (WRAP == 0) && ((mv == 2'b01 && head_q == AW'(TAPE_LEN - 1)) || (mv == 2'b10 && head_q == '0));
  assign limit = (steps_q + 16'd1) == 16'(MAX_STEPS);
  assign tape_rdata = tape_q[tape_addr];
  assign {halted, fault, timeout, head, state, steps} = {halted_q, fault_q, timeout_q, head_q, state_q, steps_q};
  // Next-state: abort freezes everything but the FSM; EXEC commits one step.
  always_comb begin
    fsm_d = fsm_q;
    ent_d = ent_q;
    head_d = head_q;
    state_d = state_q;
    steps_d = steps_q;
    halted_d = halted_q;
    fault_d = fault_q;
    timeout_d = timeout_q;
    tape_wr = 1'b0;
    if (abort) fsm_d = IDLE;
    else case (fsm_q)
      IDLE: if (start) begin
        fsm_d = FETCH;
        {head_d, state_d, steps_d, halted_d, fault_d, timeout_d} = '0;
      end
      FETCH: begin
        ent_d = tbl_q[{state_q, tape_q[head_q]}];
        fsm_d = EXEC;
      end
      EXEC: begin
        tape_wr = 1'b1;
        state_d = ent_q[EW-1 -: STATE_W];
        steps_d = steps_q + 16'd1;
        halted_d = mv == 2'b11;
        fault_d = mv != 2'b11 && off_end;
        timeout_d = mv != 2'b11 && !off_end && limit;
        head_d = (off_end || mv == 2'b11) ? head_q : mv == 2'b01 ? head_q + AW'(1) : mv == 2'b10 ? head_q - AW'(1) : head_q;
        fsm_d = (mv == 2'b11 || off_end || limit) ? DONE : FETCH;
      end
      DONE: if (!start) fsm_d = IDLE;
    endcase
  end
  // Control and machine registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      ent_q <= '0;
      {head_q, state_q, steps_q, halted_q, fault_q, timeout_q} <= '0;
    end else begin
      fsm_q <= fsm_d;
      ent_q <= ent_d;
      {head_q, state_q, steps_q, halted_q, fault_q, timeout_q} <= {head_d, state_d, steps_d, halted_d, fault_d, timeout_d};
    end
  end
  // Tape and table storage survive reset; host writes only land while idle.
  always_ff @(posedge clk) begin
    if (tape_wr && !rst) tape_q[head_q] <= ent_q[2 +: SYM_W];
    if (tape_we && !busy) tape_q[tape_addr] <= tape_wdata;
    if (prog_we && !busy) tbl_q[prog_addr] <= prog_data;
  end
endmodule

// File: doc/turing_core_param.md
TURING_CORE_PARAM -- requirements
Module: turing_core_param

Interface
REQ-001 SHALL have parameter TAPE_LEN, default 16, tape cells; a power of two, 4..256.
REQ-002 SHALL have parameter SYM_W, default 2, bits per tape symbol.
REQ-003 SHALL have parameter STATE_W, default 3, bits of machine state.
REQ-004 SHALL have parameter WRAP, default 1; 1 = head wraps at tape ends, 0 = falling off the tape faults.
REQ-005 SHALL have parameter MAX_STEPS, default 1023, step limit before timeout; 1..2^16-1.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, start request, sampled in IDLE only.
REQ-009 SHALL have port abort, input, 1, forces return to IDLE.
REQ-010 SHALL have port prog_we, input, 1, transition-table write strobe.
REQ-011 SHALL have port prog_addr, input, STATE_W+SYM_W, table index {state,symbol}.
REQ-012 SHALL have port prog_data, input, STATE_W+SYM_W+2, entry {next_state, write_sym, move[1:0]}.
REQ-013 SHALL have port tape_we, input, 1, tape write strobe.
REQ-014 SHALL have port tape_addr, input, log2(TAPE_LEN), tape write/read address.
REQ-015 SHALL have port tape_wdata, input, SYM_W, tape write data.
REQ-016 SHALL have port tape_rdata, output, SYM_W, combinational read of tape[tape_addr].
REQ-017 SHALL have outputs busy (1), halted (1), fault (1), timeout (1), head (log2(TAPE_LEN)), state (STATE_W), steps (16).

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, EXEC, DONE.
REQ-019 SHALL, in IDLE with start=1, load head=0, state=0, steps=0, clear halted/fault/timeout, and enter FETCH next cycle.
REQ-020 SHALL, in FETCH, register sym=tape[head] and entry=table[{state,sym}], then enter EXEC.
REQ-021 SHALL, in EXEC, write tape[head]=write_sym, set state=next_state, increment steps, and apply move: 00 stay, 01 head+1, 10 head-1, 11 halt.
REQ-022 SHALL, on a move=11 entry, still perform the write and state update, leave head unchanged, set halted=1, and enter DONE.
REQ-023 SHALL give one step every 2 cycles; busy=1 in FETCH and EXEC only.
REQ-024 SHALL, with WRAP=1, wrap head from TAPE_LEN-1 to 0 on right and from 0 to TAPE_LEN-1 on left.
REQ-025 SHALL, with WRAP=0 on an out-of-range move, complete the write, hold head, set fault=1, and enter DONE.
REQ-026 SHALL, when steps reaches MAX_STEPS in EXEC without halt or fault, set timeout=1 and enter DONE; halt or fault on that step takes priority and timeout stays 0.
REQ-027 SHALL return from DONE to IDLE on start=0; flags and head/state/steps hold until the next start.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL, on abort in any state, enter IDLE next cycle; a pending EXEC tape write is suppressed; flags are unchanged.
REQ-030 SHALL accept prog_we and tape_we only when busy=0; writes while busy are dropped.
REQ-031 SHALL give abort priority over start; tape_we and start in the same IDLE cycle both take effect.

Reset
REQ-032 SHALL, on rst, set FSM=IDLE, busy=halted=fault=timeout=0, head=0, state=0, steps=0, and discard any step in progress.
REQ-033 SHALL NOT clear the tape or table contents on reset.

Verification
REQ-034 SHALL cover: table[{0,0}]={0,1,01}, table[{0,1}]={0,1,11}; tape 0,0,1,... start -> halted=1, head=2, steps=3, tape[0..2]=1,1,1, done 6 cycles after the start-sampled cycle.
REQ-035 SHALL cover: WRAP=1, TAPE_LEN=4, all entries move=01 and never halting, MAX_STEPS=6 -> timeout=1, steps=6, head=2.
REQ-036 SHALL cover: WRAP=0, table[{0,0}]={0,2,10}, tape all 0 -> fault=1, head=0, tape[0]=2, steps=1.
REQ-037 SHALL cover: abort asserted in the EXEC of step 2 -> IDLE next cycle, that step's tape write absent, steps=1; a tape_we while busy leaves the tape unchanged.
REQ-038 SHALL cover: rst asserted mid-run -> all outputs at reset values next cycle, tape writes completed before the reset retained.
